db15_joy_responder: RTL and testbench



---
 rtl/db15_joy_responder.sv | 86 ++++++++
 tb/tb_db15_joy_responder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/db15_joy_responder.sv
// rtl/db15_joy_responder.sv - device end of the serial DB15 joystick link
// Snapshots two player words on load and shifts them out LSB first, active-low.
module db15_joy_responder #(
   parameter int FRAME_BITS  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic                              clk_sys,
   input  logic                              reset_n,
   input  logic [FRAME_BITS-1:0]             joystick1,
   input  logic [FRAME_BITS-1:0]             joystick2,
   input  logic                              joy_load_in,
   input  logic                              joy_clk_in,
   output logic                              joy_data_out,
   output logic                              frame_done,
   output logic [$clog2(2*FRAME_BITS):0]     bit_cnt
);

   localparam int TOTAL = 2 * FRAME_BITS;
   localparam int CNT_W = $clog2(TOTAL) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TOTAL);
   localparam logic [CNT_W-1:0] CNT_PRELST = CNT_W'(TOTAL - 2);

   localparam logic ST_LOAD  = 1'b0;
   localparam logic ST_SHIFT = 1'b1;

   logic [SYNC_STAGES-1:0] load_sync;
   logic [SYNC_STAGES-1:0] clk_sync;
   logic                   clk_prev;
   logic                   state;
   logic [TOTAL-1:0]       sr;
   logic                   armed;
   logic                   done_pend;

   logic load_s;
   logic clk_s;
   logic clk_rise;

   assign load_s   = load_sync[SYNC_STAGES-1];
   assign clk_s    = clk_sync[SYNC_STAGES-1];
   assign clk_rise = clk_s & ~clk_prev;

   // sr holds the frame already inverted (1 = released) so ones shift in as released
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         load_sync    <= '1;
         clk_sync     <= '1;
         clk_prev     <= 1'b1;
         state        <= ST_SHIFT;
         sr           <= '1;
         bit_cnt      <= '0;
         armed        <= 1'b0;
         done_pend    <= 1'b0;
         frame_done   <= 1'b0;
         joy_data_out <= 1'b1;
      end else begin
         load_sync  <= {load_sync[SYNC_STAGES-2:0], joy_load_in};
         clk_sync   <= {clk_sync[SYNC_STAGES-2:0], joy_clk_in};
         clk_prev   <= clk_s;
         frame_done <= done_pend;
         done_pend  <= 1'b0;
         if (!load_s) begin
            state        <= ST_LOAD;
            sr           <= ~{joystick2, joystick1};
            bit_cnt      <= '0;
            armed        <= 1'b0;
            joy_data_out <= ~joystick1[0];
         end else begin
            state        <= ST_SHIFT;
            joy_data_out <= sr[0];
            if (state == ST_LOAD)
               armed <= 1'b1;
            if (clk_rise) begin
               sr <= {1'b1, sr[TOTAL-1:1]};
               if (bit_cnt != CNT_MAX)
                  bit_cnt <= bit_cnt + 1'b1;
               // done is delayed one cycle to line up with the registered data output
               if (armed && bit_cnt == CNT_PRELST) begin
                  done_pend <= 1'b1;
                  armed     <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_db15_joy_responder.sv
// tb/tb_db15_joy_responder.sv - randomized self-checking bench for db15_joy_responder
module tb_db15_joy_responder;

   localparam int FB    = 16;
   localparam int TOTAL = 2 * FB;
   localparam int HOLD  = 6;

   logic          clk_sys = 1'b0;
   logic          reset_n = 1'b0;
   logic [FB-1:0] joystick1 = '0;
   logic [FB-1:0] joystick2 = '0;
   logic          joy_load_in = 1'b1;
   logic          joy_clk_in = 1'b1;
   logic          joy_data_out;
   logic          frame_done;
   logic [5:0]    bit_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int edges    = 0;
   int done_cnt = 0;
   int done_at  = -1;
   logic [TOTAL-1:0] snap;

   db15_joy_responder #(.FRAME_BITS(FB), .SYNC_STAGES(2)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .joystick1(joystick1), .joystick2(joystick2),
      .joy_load_in(joy_load_in), .joy_clk_in(joy_clk_in), .joy_data_out(joy_data_out),
      .frame_done(frame_done), .bit_cnt(bit_cnt)
   );

   always #10 clk_sys = ~clk_sys;

   always @(negedge clk_sys) begin
      if (frame_done) begin
         done_cnt = done_cnt + 1;
         done_at  = edges;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Reference: after k edges the line shows frame bit k inverted, released once past the end
   function automatic logic exp_data(input logic [TOTAL-1:0] s, input int k);
      return (k < TOTAL) ? ~s[k] : 1'b1;
   endfunction

   function automatic int exp_cnt(input int k);
      return (k < TOTAL) ? k : TOTAL;
   endfunction

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk_sys);
   endtask

   task automatic do_load(input logic [FB-1:0] j1, input logic [FB-1:0] j2);
      joystick1   = j1;
      joystick2   = j2;
      snap        = {j2, j1};
      joy_load_in = 1'b0;
      wait_cycles(HOLD);
      joy_load_in = 1'b1;
      wait_cycles(HOLD);
      edges    = 0;
      done_cnt = 0;
      done_at  = -1;
   endtask

   task automatic do_edge();
      joy_clk_in = 1'b0;
      wait_cycles(HOLD);
      joy_clk_in = 1'b1;
      edges = edges + 1;
      wait_cycles(HOLD);
   endtask

   task automatic test_reset();
      reset_n   = 1'b0;
      joystick1 = 16'hFFFF;
      wait_cycles(3);
      n_checks++;
      if (joy_data_out !== 1'b1 || bit_cnt !== 6'd0 || frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_values: data=%b cnt=%0d done=%b required data=1 cnt=0 done=0",
                  joy_data_out, bit_cnt, frame_done);
      end
      joy_clk_in = 1'b0;
      wait_cycles(2);
      joy_clk_in = 1'b1;
      wait_cycles(2);
      reset_n = 1'b1;
      wait_cycles(HOLD);
      n_checks++;
      if (joy_data_out !== 1'b1 || bit_cnt !== 6'd0) begin
         n_fail++;
         $display("FAIL reset_release: data=%b cnt=%0d required data=1 cnt=0", joy_data_out, bit_cnt);
      end
   endtask

   task automatic test_basic_frame();
      do_load(16'h0005, 16'h8002);
      for (int k = 0; k <= TOTAL + 8; k++) begin
         if (k > 0) do_edge();
         n_checks++;
         if (joy_data_out !== exp_data(snap, k) || int'(bit_cnt) != exp_cnt(k)) begin
            n_fail++;
            $display("FAIL basic_bit%0d: data=%b cnt=%0d required data=%b cnt=%0d",
                     k, joy_data_out, bit_cnt, exp_data(snap, k), exp_cnt(k));
         end
      end
      n_checks++;
      if (done_cnt != 1 || done_at != TOTAL - 1) begin
         n_fail++;
         $display("FAIL basic_frame_done: pulses=%0d at_edge=%0d required pulses=1 at_edge=%0d",
                  done_cnt, done_at, TOTAL - 1);
      end
   endtask

   task automatic test_load_priority();
      logic [FB-1:0] j1;
      j1 = FB'($urandom) | 16'h0002;
      joystick1  = j1;
      joystick2  = FB'($urandom);
      snap       = {joystick2, j1};
      joy_clk_in = 1'b0;
      wait_cycles(HOLD);
      joy_load_in = 1'b0;
      joy_clk_in  = 1'b1;
      wait_cycles(HOLD);
      n_checks++;
      if (bit_cnt !== 6'd0 || joy_data_out !== ~j1[0]) begin
         n_fail++;
         $display("FAIL load_priority_during: cnt=%0d data=%b required cnt=0 data=%b",
                  bit_cnt, joy_data_out, ~j1[0]);
      end
      joy_load_in = 1'b1;
      wait_cycles(HOLD);
      edges = 0;
      n_checks++;
      if (bit_cnt !== 6'd0 || joy_data_out !== ~j1[0]) begin
         n_fail++;
         $display("FAIL load_priority_after: cnt=%0d data=%b required cnt=0 data=%b",
                  bit_cnt, joy_data_out, ~j1[0]);
      end
      do_edge();
      n_checks++;
      if (bit_cnt !== 6'd1 || joy_data_out !== exp_data(snap, 1)) begin
         n_fail++;
         $display("FAIL load_priority_first_edge: cnt=%0d data=%b required cnt=1 data=%b",
                  bit_cnt, joy_data_out, exp_data(snap, 1));
      end
   endtask

   task automatic test_input_change();
      do_load(FB'($urandom), FB'($urandom));
      for (int k = 1; k <= TOTAL; k++) begin
         do_edge();
         if (k == 4) begin
            joystick1 = 16'h0000;
            joystick2 = FB'($urandom);
         end
         n_checks++;
         if (joy_data_out !== exp_data(snap, k)) begin
            n_fail++;
            $display("FAIL midchange_bit%0d: data=%b required %b", k, joy_data_out, exp_data(snap, k));
         end
      end
      do_load(16'h0000, 16'h0000);
      for (int k = 0; k < 6; k++) begin
         if (k > 0) do_edge();
         n_checks++;
         if (joy_data_out !== 1'b1) begin
            n_fail++;
            $display("FAIL released_bit%0d: data=%b required 1", k, joy_data_out);
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      do_load(FB'($urandom) | 16'h0400, FB'($urandom));
      for (int k = 1; k <= 10; k++) do_edge();
      n_checks++;
      if (joy_data_out !== 1'b0) begin
         n_fail++;
         $display("FAIL pre_reset_bit10: data=%b required 0", joy_data_out);
      end
      reset_n = 1'b0;
      #1;
      n_checks++;
      if (joy_data_out !== 1'b1 || bit_cnt !== 6'd0 || frame_done !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: data=%b cnt=%0d done=%b required data=1 cnt=0 done=0",
                  joy_data_out, bit_cnt, frame_done);
      end
      wait_cycles(3);
      reset_n  = 1'b1;
      wait_cycles(2);
      done_cnt = 0;
      edges    = 0;
      for (int k = 1; k <= TOTAL + 2; k++) begin
         do_edge();
         n_checks++;
         if (joy_data_out !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset_idle_bit%0d: data=%b required 1", k, joy_data_out);
         end
      end
      n_checks++;
      if (done_cnt != 0) begin
         n_fail++;
         $display("FAIL post_reset_no_done: pulses=%0d required 0", done_cnt);
      end
   endtask

   task automatic test_random_frames();
      for (int f = 0; f < 4; f++) begin
         do_load(FB'($urandom), FB'($urandom));
         for (int k = 0; k <= TOTAL + 1; k++) begin
            if (k > 0) do_edge();
            n_checks++;
            if (joy_data_out !== exp_data(snap, k) || int'(bit_cnt) != exp_cnt(k)) begin
               n_fail++;
               $display("FAIL rand%0d_bit%0d: data=%b cnt=%0d required data=%b cnt=%0d",
                        f, k, joy_data_out, bit_cnt, exp_data(snap, k), exp_cnt(k));
            end
         end
         n_checks++;
         if (done_cnt != 1 || done_at != TOTAL - 1) begin
            n_fail++;
            $display("FAIL rand%0d_frame_done: pulses=%0d at_edge=%0d required pulses=1 at_edge=%0d",
                     f, done_cnt, done_at, TOTAL - 1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_load_priority();
      test_input_change();
      test_reset_mid_frame();
      test_random_frames();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
